in_fm_ld_addr_gen: RTL
======================

IN_FM_LD_ADDR_GEN -- requirements
Module: in_fm_ld_addr_gen

Interface
REQ-001 SHALL have parameter: CW, 16, width of tile dimension counters.
REQ-002 SHALL have parameter: AW, 32, width of read address and strides.
REQ-003 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous reset, active-low.
REQ-005 SHALL have port: load_start  input  1  one-cycle pulse starting a tile load.
REQ-006 SHALL have port: syn_rst  input  1  synchronous abort/clear.
REQ-007 SHALL have ports: n0_max, n1_max, n2_max  input  CW each  tile column, row and channel counts.
REQ-008 SHALL have ports: base_addr, row_stride, plane_stride  input  AW each  tile origin, words per row, words per channel plane.
REQ-009 SHALL have port: rd_valid  output  1  read request valid.
REQ-010 SHALL have port: rd_ready  input  1  read request accepted by memory side.
REQ-011 SHALL have port: rd_addr  output  AW  word address of current request.
REQ-012 SHALL have ports: cnt0, cnt1, cnt2  output  CW each  column, row and channel index of current request.
REQ-013 SHALL have port: busy  output  1  high in RUN state.
REQ-014 SHALL have port: done  output  1  one-cycle pulse after last request accepted.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 SHALL, in IDLE on load_start=1, latch n0_max, n1_max, n2_max, base_addr, row_stride and plane_stride; later input changes do not affect the running load.
REQ-017 SHALL, from IDLE with load_start=1 and all latched maxima nonzero, enter RUN next cycle with rd_valid=1, rd_addr=base_addr and cnt0=cnt1=cnt2=0.
REQ-018 SHALL, from IDLE with load_start=1 and any maximum equal to 0, go to DONE with no request issued.
REQ-019 SHALL define a handshake as rd_valid=1 and rd_ready=1 in the same cycle.
REQ-020 SHALL, while rd_valid=1 and rd_ready=0, hold rd_addr, cnt0, cnt1 and cnt2 stable.
REQ-021 SHALL keep rd_valid=1 throughout RUN, so back-to-back requests are issued, one per cycle, while rd_ready=1.
REQ-022 SHALL advance cnt0 on each handshake.
REQ-023 SHALL, at cnt0=n0_max-1, wrap cnt0 to 0 and increment cnt1.
REQ-024 SHALL, at cnt1=n1_max-1 with cnt0 wrapping, wrap cnt1 to 0 and increment cnt2.
REQ-025 SHALL compute addresses incrementally with registered plane_base and row_base and no multipliers: rd_addr = base + cnt2*plane_stride + cnt1*row_stride + cnt0, modulo 2^AW.
REQ-026 SHALL, on the handshake at cnt0=n0_max-1, cnt1=n1_max-1 and cnt2=n2_max-1, deassert rd_valid next cycle and enter DONE.
REQ-027 SHALL, in DONE, assert done for exactly one cycle, clear counters to 0 and return to IDLE next cycle.
REQ-028 SHALL ignore load_start in RUN and DONE.
REQ-029 SHALL, on syn_rst=1 in any state, return to IDLE next cycle with rd_valid=0, counters 0 and no done pulse; syn_rst has priority over load_start.
REQ-030 SHALL drive busy=1 exactly while in RUN.
REQ-031 SHALL keep rd_addr at its last value when rd_valid=0.

Reset
REQ-032 SHALL, with rst=0 asynchronously, force IDLE with rd_valid, busy and done at 0, rd_addr at 0 and cnt0/cnt1/cnt2 at 0.
REQ-033 SHALL discard any in-progress load on reset and issue no further requests until a new load_start after rst returns to 1.

Verification
REQ-034 SHALL verify: n0=3, n1=2, n2=2, base=0x100, row_stride=0x10, plane_stride=0x40, rd_ready=1 -> addresses 0x100,0x101,0x102,0x110,0x111,0x112,0x140,0x141,0x142,0x150,0x151,0x152 on consecutive cycles, then done pulse for 1 cycle.
REQ-035 SHALL verify: same config with rd_ready toggling 1,0,1,0 -> same 12-address sequence, each held while rd_ready=0, 12 handshakes total.
REQ-036 SHALL verify: n1_max=0 with load_start -> no rd_valid and done 1 cycle later.
REQ-037 SHALL verify: syn_rst after 5th handshake -> rd_valid=0 next cycle, counters 0, no done; a new load_start restarts at base.
REQ-038 SHALL verify: rst=0 mid-load -> immediate rd_valid=0 and busy=0; load_start during RUN is ignored.
REQ-039 SHALL verify: base=0xFFFFFFFE, n0=4, n1=n2=1 -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 (wrap).

Source files
------------

// File: rtl/in_fm_ld_addr_gen.sv
// Input feature-map tile load address generator: walks column/row/channel counters and emits one word read per handshake.
// First request one cycle after load_start; holds the request while rd_ready=0, back-to-back when rd_ready=1.
module in_fm_ld_addr_gen #(
  parameter int CW = 16,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic          syn_rst,
  input  logic [CW-1:0] n0_max,
  input  logic [CW-1:0] n1_max,
  input  logic [CW-1:0] n2_max,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] row_stride,
  input  logic [AW-1:0] plane_stride,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [AW-1:0] rd_addr,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] cnt2,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] n0_q, n1_q, n2_q;
  logic [AW-1:0] row_stride_q, plane_stride_q;
  logic [AW-1:0] row_base, plane_base;

  logic          hs;
  logic          last0, last1, last2;
  logic          cfg_ok;
  logic [AW-1:0] next_row, next_plane;

  assign hs         = rd_valid & rd_ready;
  assign last0      = (cnt0 == n0_q - CW'(1));
  assign last1      = (cnt1 == n1_q - CW'(1));
  assign last2      = (cnt2 == n2_q - CW'(1));
  assign cfg_ok     = (n0_max != '0) && (n1_max != '0) && (n2_max != '0);
  // Row/plane origins advance by addition only, so no multipliers are needed.
  assign next_row   = row_base + row_stride_q;
  assign next_plane = plane_base + plane_stride_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      rd_valid       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      rd_addr        <= '0;
      cnt0           <= '0;
      cnt1           <= '0;
      cnt2           <= '0;
      n0_q           <= '0;
      n1_q           <= '0;
      n2_q           <= '0;
      row_stride_q   <= '0;
      plane_stride_q <= '0;
      row_base       <= '0;
      plane_base     <= '0;
    end else if (syn_rst) begin
      state    <= IDLE;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt0     <= '0;
      cnt1     <= '0;
      cnt2     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (load_start) begin
            n0_q           <= n0_max;
            n1_q           <= n1_max;
            n2_q           <= n2_max;
            row_stride_q   <= row_stride;
            plane_stride_q <= plane_stride;
            row_base       <= base_addr;
            plane_base     <= base_addr;
            cnt0           <= '0;
            cnt1           <= '0;
            cnt2           <= '0;
            if (cfg_ok) begin
              state    <= RUN;
              rd_valid <= 1'b1;
              busy     <= 1'b1;
              rd_addr  <= base_addr;
            end else begin
              // Empty tile: finish without issuing any request.
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        RUN: begin
          if (hs) begin
            if (!last0) begin
              cnt0    <= cnt0 + CW'(1);
              rd_addr <= rd_addr + AW'(1);
            end else if (!last1) begin
              cnt0     <= '0;
              cnt1     <= cnt1 + CW'(1);
              row_base <= next_row;
              rd_addr  <= next_row;
            end else if (!last2) begin
              cnt0       <= '0;
              cnt1       <= '0;
              cnt2       <= cnt2 + CW'(1);
              plane_base <= next_plane;
              row_base   <= next_plane;
              rd_addr    <= next_plane;
            end else begin
              // Final word accepted; rd_addr keeps its last value.
              state    <= DONE;
              rd_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              cnt0     <= '0;
              cnt1     <= '0;
              cnt2     <= '0;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          cnt0  <= '0;
          cnt1  <= '0;
          cnt2  <= '0;
        end

        default: begin
          state    <= IDLE;
          rd_valid <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule
